serial_adder_ctrl: RTL

//  Multi-cycle sequencer that adds two WIDTH-bit operands through a single
//  4-bit ripple-carry slice (four fulladder cells), one nibble per clock.

---
 rtl/serial_adder_ctrl.sv | 120 ++++++++++++
 1 files changed

// File: rtl/serial_adder_ctrl.sv
// Serial wide adder: one 4-bit ripple slice reused once per nibble, with the
// carry held in a register between passes, behind a valid/ready handshake.

module serial_adder_fa (
   input  logic i_a,
   input  logic i_b,
   input  logic i_c,
   output logic o_s,
   output logic o_c
);
   assign o_s = i_a ^ i_b ^ i_c;
   assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

module serial_adder_ctrl #(
   parameter int WIDTH = 16
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_in_valid,
   output logic             o_in_ready,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_cin,
   output logic             o_out_valid,
   input  logic             i_out_ready,
   output logic [WIDTH-1:0] o_sum,
   output logic             o_cout,
   output logic             o_busy
);
   localparam int NUM_LANES = 4;
   localparam int NCHUNK    = WIDTH / NUM_LANES;
   localparam int CW        = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]           r_state;
   logic [CW-1:0]        r_cnt;
   logic                 r_carry;
   logic [WIDTH-1:0]     r_a_sh;
   logic [WIDTH-1:0]     r_b_sh;
   logic [WIDTH-1:0]     r_sum;
   logic                 r_cout;

   logic [NUM_LANES:0]   w_c;
   logic [NUM_LANES-1:0] w_slice_sum;
   logic [WIDTH-1:0]     w_sum_next;
   logic                 w_last;

   // Slice carry-in comes from the register, so the chain ripples across passes.
   assign w_c[0] = r_carry;

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      serial_adder_fa u_fa (
         .i_a (r_a_sh[g]),
         .i_b (r_b_sh[g]),
         .i_c (w_c[g]),
         .o_s (w_slice_sum[g]),
         .o_c (w_c[g+1])
      );
   end

   // New nibble enters at the top; after NCHUNK passes the first one sits at bit 0.
   if (WIDTH == NUM_LANES) begin : g_sum_narrow
      assign w_sum_next = w_slice_sum;
   end else begin : g_sum_wide
      assign w_sum_next = {w_slice_sum, r_sum[WIDTH-1:NUM_LANES]};
   end

   assign w_last = (r_cnt == CW'(NCHUNK - 1));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_carry <= 1'b0;
         r_a_sh  <= '0;
         r_b_sh  <= '0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_in_valid) begin
                  r_a_sh  <= i_a;
                  r_b_sh  <= i_b;
                  r_carry <= i_cin;
                  r_cnt   <= '0;
                  r_sum   <= '0;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               r_sum   <= w_sum_next;
               r_carry <= w_c[NUM_LANES];
               r_a_sh  <= r_a_sh >> NUM_LANES;
               r_b_sh  <= r_b_sh >> NUM_LANES;
               r_cnt   <= r_cnt + CW'(1);
               if (w_last) begin
                  r_cout  <= w_c[NUM_LANES];
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               if (i_out_ready) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_in_ready  = (r_state == S_IDLE);
   assign o_out_valid = (r_state == S_DONE);
   assign o_busy      = (r_state != S_IDLE);
   assign o_sum       = r_sum;
   assign o_cout      = r_cout;

endmodule
